// File: rtl/int_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | int_sched: edge-latched, maskable, fixed-priority interrupt scheduler  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module int_sched #(
  parameter int                 NUM_IRQ    = 6,
  parameter logic [15:0]        VEC_BASE   = 16'h10,
  parameter logic [15:0]        VEC_STRIDE = 16'h4,
  parameter logic [NUM_IRQ-1:0] NMI_MASK   = 6'b000001
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               priv_lv,
  output logic               cpu_irq,
  input  logic               cpu_irq_ack,
  output logic [15:0]        int_addr,
  output logic [2:0]         cur_irq,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pend,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] lost,
  input  logic               lost_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   prev_q, prev_d;
  logic [NUM_IRQ-1:0]   pend_q, pend_d;
  logic [NUM_IRQ-1:0]   lost_q, lost_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic                 cpu_irq_q, cpu_irq_d;
  logic [15:0]          int_addr_q, int_addr_d;
  logic [2:0]           cur_irq_q, cur_irq_d;

  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   grant_clr;
  logic [2:0]           win;
  logic                 grant;

  always_comb begin
    rise     = irq & ~prev_q;
    eligible = pend_q & (mask_q | NMI_MASK);
    // Descending scan leaves the lowest eligible index as the winner.
    win = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win = 3'(i);
    end
    grant = (state_q == IDLE) && priv_lv && (|eligible);
    for (int i = 0; i < NUM_IRQ; i++) begin
      grant_clr[i] = grant && (win == 3'(i));
    end

    state_d    = state_q;
    prev_d     = irq;
    cpu_irq_d  = cpu_irq_q;
    int_addr_d = int_addr_q;
    cur_irq_d  = cur_irq_q;
    mask_d     = mask_we ? mask_wdata : mask_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          cur_irq_d  = win;
          int_addr_d = VEC_BASE + ({13'd0, win} * VEC_STRIDE);
          cpu_irq_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (cpu_irq_ack) begin
          cpu_irq_d = 1'b0;
          state_d   = SERVICE;
        end
      end
      SERVICE: begin
        if (priv_lv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge beats the grant clear and is not counted as lost.
    pend_d = (pend_q & ~grant_clr) | rise;
    lost_d = (lost_clr ? '0 : lost_q) | (rise & pend_q & ~grant_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= '1;
      pend_q     <= '0;
      lost_q     <= '0;
      mask_q     <= '1;
      cpu_irq_q  <= 1'b0;
      int_addr_q <= 16'h0;
      cur_irq_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      lost_q     <= lost_d;
      mask_q     <= mask_d;
      cpu_irq_q  <= cpu_irq_d;
      int_addr_q <= int_addr_d;
      cur_irq_q  <= cur_irq_d;
    end
  end

  assign cpu_irq    = cpu_irq_q;
  assign int_addr   = int_addr_q;
  assign cur_irq    = cur_irq_q;
  assign in_service = (state_q != IDLE);
  assign pend       = pend_q;
  assign mask       = mask_q;
  assign lost       = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_int_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_int_sched: directed stimulus, cycle model and literal checks        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_int_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] irq = 6'd0;
  logic       priv_lv = 1'b1;
  logic       cpu_irq;
  logic       cpu_irq_ack = 1'b0;
  logic [15:0] int_addr;
  logic [2:0] cur_irq;
  logic       in_service;
  logic [5:0] pend;
  logic       mask_we = 1'b0;
  logic [5:0] mask_wdata = 6'd0;
  logic [5:0] mask;
  logic [5:0] lost;
  logic       lost_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  int_sched dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .priv_lv(priv_lv),
    .cpu_irq(cpu_irq), .cpu_irq_ack(cpu_irq_ack), .int_addr(int_addr),
    .cur_irq(cur_irq), .in_service(in_service), .pend(pend),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask(mask),
    .lost(lost), .lost_clr(lost_clr)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = free, 1 = waiting for ack, 2 = in handler.
  bit [5:0]  m_prev = '1, m_pend = '0, m_lost = '0, m_mask = '1;
  bit [5:0]  m_edges;
  int        m_phase = 0, m_cur = 0, m_win;
  bit        m_cpu = 0;
  bit [15:0] m_addr = 0;
  localparam bit [5:0] NMI = 6'b000001;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_prev = '1; m_pend = '0; m_lost = '0; m_mask = '1;
      m_phase = 0; m_cur = 0; m_cpu = 0; m_addr = 0;
    end else begin
      m_edges = irq & ~m_prev;
      m_win = -1;
      if (m_phase == 0 && priv_lv)
        for (int i = 5; i >= 0; i--)
          if (m_pend[i] && (m_mask[i] || NMI[i])) m_win = i;
      if (lost_clr) m_lost = '0;
      for (int i = 0; i < 6; i++)
        if (m_edges[i] && m_pend[i] && i != m_win) m_lost[i] = 1'b1;
      if (m_win >= 0) begin
        m_pend[m_win] = 1'b0;
        m_cur = m_win;
        m_addr = 16'h10 + 16'(m_win) * 16'h4;
        m_cpu = 1'b1;
        m_phase = 1;
      end else if (m_phase == 1 && cpu_irq_ack) begin
        m_cpu = 1'b0;
        m_phase = 2;
      end else if (m_phase == 2 && priv_lv) begin
        m_phase = 0;
      end
      m_pend = m_pend | m_edges;
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_cpu_irq", 32'(cpu_irq), 32'(m_cpu));
      chk("m_int_addr", 32'(int_addr), 32'(m_addr));
      chk("m_cur_irq", 32'(cur_irq), 32'(m_cur));
      chk("m_in_service", 32'(in_service), 32'(m_phase != 0));
      chk("m_pend", 32'(pend), 32'(m_pend));
      chk("m_mask", 32'(mask), 32'(m_mask));
      chk("m_lost", 32'(lost), 32'(m_lost));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic service();
    cpu_irq_ack = 1'b1;
    tick(1);
    cpu_irq_ack = 1'b0;
    tick(1);
  endtask

  task automatic write_mask(input logic [5:0] v);
    mask_we = 1'b1;
    mask_wdata = v;
    tick(1);
    mask_we = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("reset_cpu_irq", 32'(cpu_irq), 32'd0);
    chk("reset_pend", 32'(pend), 32'd0);
    chk("reset_mask", 32'(mask), 32'h3f);
    chk("reset_int_addr", 32'(int_addr), 32'd0);
    chk("reset_in_service", 32'(in_service), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single line
    irq = 6'b000010; tick(1);
    irq = 6'b000000; tick(1);
    chk("single_cpu_irq", 32'(cpu_irq), 32'd1);
    chk("single_addr", 32'(int_addr), 32'h14);
    chk("single_cur", 32'(cur_irq), 32'd1);
    chk("single_pend", 32'(pend), 32'd0);
    cpu_irq_ack = 1'b1; tick(1);
    cpu_irq_ack = 1'b0; priv_lv = 1'b0;
    chk("single_ack", 32'(cpu_irq), 32'd0);
    tick(1);
    chk("single_in_svc", 32'(in_service), 32'd1);
    priv_lv = 1'b1; tick(1);
    chk("single_return", 32'(in_service), 32'd0);

    // Priority
    irq = 6'b100100; tick(1);
    irq = 6'b000000; tick(1);
    chk("prio_first", 32'(int_addr), 32'h18);
    service();
    tick(1);
    chk("prio_second", 32'(int_addr), 32'h24);
    chk("prio_second_cur", 32'(cur_irq), 32'd5);
    service();

    // Mask and NMI
    write_mask(6'b000000);
    irq = 6'b000011; tick(1);
    irq = 6'b000000; tick(1);
    chk("nmi_addr", 32'(int_addr), 32'h10);
    chk("nmi_pend", 32'(pend), 32'b000010);
    cpu_irq_ack = 1'b1; tick(1);
    cpu_irq_ack = 1'b0;
    write_mask(6'b000010);
    tick(1);
    chk("unmask_grant", 32'(cpu_irq), 32'd1);
    chk("unmask_addr", 32'(int_addr), 32'h14);
    service();
    write_mask(6'b111111);

    // System mode blocking
    priv_lv = 1'b0;
    irq = 6'b001000; tick(1);
    irq = 6'b000000; tick(2);
    chk("sys_block", 32'(cpu_irq), 32'd0);
    chk("sys_pend", 32'(pend), 32'b001000);
    priv_lv = 1'b1; tick(1);
    chk("sys_release", 32'(cpu_irq), 32'd1);
    chk("sys_addr", 32'(int_addr), 32'h1c);
    service();

    // Edge coinciding with grant clear on the same line
    priv_lv = 1'b0;
    irq = 6'b001000; tick(1);
    irq = 6'b000000; tick(1);
    priv_lv = 1'b1; irq = 6'b001000; tick(1);
    irq = 6'b000000;
    chk("race_grant", 32'(cpu_irq), 32'd1);
    chk("race_pend", 32'(pend), 32'b001000);
    chk("race_lost", 32'(lost), 32'd0);
    service();
    tick(1);
    chk("race_regrant", 32'(int_addr), 32'h1c);
    service();

    // Coalescing and lost
    priv_lv = 1'b0;
    irq = 6'b010000; tick(1);
    irq = 6'b000000; tick(1);
    irq = 6'b010000; tick(1);
    irq = 6'b000000; tick(1);
    chk("coal_lost", 32'(lost), 32'b010000);
    chk("coal_pend", 32'(pend), 32'b010000);
    lost_clr = 1'b1; tick(1);
    lost_clr = 1'b0;
    chk("coal_clr", 32'(lost), 32'd0);
    irq = 6'b010000; lost_clr = 1'b1; tick(1);
    irq = 6'b000000; lost_clr = 1'b0;
    chk("coal_set_wins", 32'(lost), 32'b010000);
    lost_clr = 1'b1; tick(1);
    lost_clr = 1'b0;
    priv_lv = 1'b1; tick(1);
    chk("coal_grant", 32'(int_addr), 32'h20);
    service();
    tick(2);
    chk("coal_once", 32'(cpu_irq), 32'd0);

    // Reset mid-REQ
    write_mask(6'b111100);
    irq = 6'b000100; tick(2);
    chk("rst_pre", 32'(cpu_irq), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_cpu_irq", 32'(cpu_irq), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_mask", 32'(mask), 32'h3f);
    chk("rst_in_svc", 32'(in_service), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_no_grant", 32'(cpu_irq), 32'd0);
    chk("rst_no_pend", 32'(pend), 32'd0);
    irq = 6'b000000;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
